// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries prediction metadata IF->ID->EX, issues one
// BTB/predictor update per resolved branch, and redirects/flushes on mispredicts.
module branch_resolve_unit #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             if_valid_i,
  input  logic [31:0]      if_pc_i,
  input  logic             if_pred_taken_i,
  input  logic [31:0]      if_pred_target_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_taken_i,
  input  logic [31:0]      ex_target_i,
  output logic             btb_we_o,
  output logic [IDX_W-1:0] btb_index_o,
  output logic [TAG_W-1:0] btb_tag_o,
  output logic [31:0]      btb_target_o,
  output logic             btb_taken_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t state_q, state_d;

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_pred_taken_q, id_pred_taken_d;
  logic [31:0] id_pred_target_q, id_pred_target_d;
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic        ex_pred_taken_q, ex_pred_taken_d;
  logic [31:0] ex_pred_target_q, ex_pred_target_d;
  logic        ex_done_q, ex_done_d;

  logic             btb_we_q, btb_we_d;
  logic [IDX_W-1:0] btb_index_q, btb_index_d;
  logic [TAG_W-1:0] btb_tag_q, btb_tag_d;
  logic [31:0]      btb_target_q, btb_target_d;
  logic             btb_taken_q, btb_taken_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic        resolve_s;
  logic        mispred_s;
  logic        kill_pipe_s;
  logic [31:0] correct_pc_s;

  assign resolve_s = ex_valid_q && ex_is_branch_i && !ex_done_q;
  assign mispred_s = resolve_s &&
                     ((ex_pred_taken_q != ex_taken_i) ||
                      (ex_pred_taken_q && ex_taken_i && (ex_pred_target_q != ex_target_i)));
  assign correct_pc_s = ex_taken_i ? ex_target_i : (ex_pc_q + 32'd4);

  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    flush_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    kill_pipe_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mispred_s) begin
          redirect_d    = 1'b1;
          flush_d       = 1'b1;
          redirect_pc_d = correct_pc_s;
          kill_pipe_s   = 1'b1;
          state_d       = FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Metadata shift; a mispredict kills both stages even while stalled.
  always_comb begin
    id_valid_d       = id_valid_q;
    id_pc_d          = id_pc_q;
    id_pred_taken_d  = id_pred_taken_q;
    id_pred_target_d = id_pred_target_q;
    ex_valid_d       = ex_valid_q;
    ex_pc_d          = ex_pc_q;
    ex_pred_taken_d  = ex_pred_taken_q;
    ex_pred_target_d = ex_pred_target_q;
    ex_done_d        = ex_done_q | resolve_s;
    if (!stall_i) begin
      id_valid_d       = if_valid_i;
      id_pc_d          = if_pc_i;
      id_pred_taken_d  = if_pred_taken_i;
      id_pred_target_d = if_pred_target_i;
      ex_valid_d       = id_valid_q;
      ex_pc_d          = id_pc_q;
      ex_pred_taken_d  = id_pred_taken_q;
      ex_pred_target_d = id_pred_target_q;
      ex_done_d        = 1'b0;
    end
    if (kill_pipe_s) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
    end
  end

  always_comb begin
    btb_we_d      = resolve_s;
    btb_index_d   = btb_index_q;
    btb_tag_d     = btb_tag_q;
    btb_target_d  = btb_target_q;
    btb_taken_d   = btb_taken_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve_s) begin
      btb_index_d  = ex_pc_q[IDX_W+1:2];
      btb_tag_d    = ex_pc_q[IDX_W+TAG_W+1:IDX_W+2];
      btb_target_d = ex_target_i;
      btb_taken_d  = ex_taken_i;
      if (branch_cnt_q != {CNT_W{1'b1}}) begin
        branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
    if (mispred_s && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      id_valid_q       <= 1'b0;
      id_pc_q          <= 32'd0;
      id_pred_taken_q  <= 1'b0;
      id_pred_target_q <= 32'd0;
      ex_valid_q       <= 1'b0;
      ex_pc_q          <= 32'd0;
      ex_pred_taken_q  <= 1'b0;
      ex_pred_target_q <= 32'd0;
      ex_done_q        <= 1'b0;
      btb_we_q         <= 1'b0;
      btb_index_q      <= '0;
      btb_tag_q        <= '0;
      btb_target_q     <= 32'd0;
      btb_taken_q      <= 1'b0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      id_valid_q       <= id_valid_d;
      id_pc_q          <= id_pc_d;
      id_pred_taken_q  <= id_pred_taken_d;
      id_pred_target_q <= id_pred_target_d;
      ex_valid_q       <= ex_valid_d;
      ex_pc_q          <= ex_pc_d;
      ex_pred_taken_q  <= ex_pred_taken_d;
      ex_pred_target_q <= ex_pred_target_d;
      ex_done_q        <= ex_done_d;
      btb_we_q         <= btb_we_d;
      btb_index_q      <= btb_index_d;
      btb_tag_q        <= btb_tag_d;
      btb_target_q     <= btb_target_d;
      btb_taken_q      <= btb_taken_d;
      redirect_q       <= redirect_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign btb_we_o      = btb_we_q;
  assign btb_index_o   = btb_index_q;
  assign btb_tag_o     = btb_tag_q;
  assign btb_target_o  = btb_target_q;
  assign btb_taken_o   = btb_taken_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign flush_o       = flush_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus stall, flush,
// saturation and async-reset sequences.
module tb_branch_resolve_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic        if_pred_taken_i;
  logic [31:0] if_pred_target_i;
  logic        ex_is_branch_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        btb_we_o;
  logic [7:0]  btb_index_o;
  logic [3:0]  btb_tag_o;
  logic [31:0] btb_target_o;
  logic        btb_taken_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_resolve_unit #(.IDX_W(8), .TAG_W(4), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
    .if_pred_taken_i(if_pred_taken_i), .if_pred_target_i(if_pred_target_i),
    .ex_is_branch_i(ex_is_branch_i), .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .btb_we_o(btb_we_o), .btb_index_o(btb_index_o), .btb_tag_o(btb_tag_o),
    .btb_target_o(btb_target_o), .btb_taken_o(btb_taken_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        is_br;
    logic        tk;
    logic [31:0] tgt;
    logic        e_we;
    logic [7:0]  e_idx;
    logic [3:0]  e_tag;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic [31:0] e_bcnt;
    logic [31:0] e_mcnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i          = 1'b0;
    if_valid_i       = 1'b0;
    if_pc_i          = 32'd0;
    if_pred_taken_i  = 1'b0;
    if_pred_target_i = 32'd0;
    ex_is_branch_i   = 1'b0;
    ex_taken_i       = 1'b0;
    ex_target_i      = 32'd0;
  endtask

  // Push one instruction through IF and ID into EX (two edges).
  task automatic load_ex(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
    if_valid_i       = 1'b1;
    if_pc_i          = pc;
    if_pred_taken_i  = pt;
    if_pred_target_i = ptg;
    tick();
    if_valid_i = 1'b0;
    tick();
  endtask

  task automatic run_vec(input int k, input vec_t v);
    string s;
    load_ex(v.pc, v.pt, v.ptg);
    ex_is_branch_i = v.is_br;
    ex_taken_i     = v.tk;
    ex_target_i    = v.tgt;
    tick();
    s = $sformatf("v%0d", k);
    chk({s, "_we"},    {31'd0, btb_we_o},   {31'd0, v.e_we});
    chk({s, "_redir"}, {31'd0, redirect_o}, {31'd0, v.e_redir});
    chk({s, "_flush"}, {31'd0, flush_o},    {31'd0, v.e_redir});
    chk({s, "_rpc"},   redirect_pc_o,       v.e_rpc);
    chk({s, "_bcnt"},  branch_cnt_o,        v.e_bcnt);
    chk({s, "_mcnt"},  mispred_cnt_o,       v.e_mcnt);
    if (v.e_we) begin
      chk({s, "_idx"},   {24'd0, btb_index_o},  {24'd0, v.e_idx});
      chk({s, "_tag"},   {28'd0, btb_tag_o},    {28'd0, v.e_tag});
      chk({s, "_btgt"},  btb_target_o,          v.tgt);
      chk({s, "_btk"},   {31'd0, btb_taken_o},  {31'd0, v.tk});
    end
    ex_is_branch_i = 1'b0;
    tick();
    chk({s, "_we_off"},    {31'd0, btb_we_o},   32'd0);
    chk({s, "_redir_off"}, {31'd0, redirect_o}, 32'd0);
  endtask

  initial begin : main
    int pulses;

    //            pc            pt    ptg           br    tk    tgt           we    idx    tag   red   rpc           bcnt   mcnt
    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0180, 1'b1, 8'h40, 4'h0, 1'b0, 32'h0000_0000, 32'd1, 32'd0};
    vecs[1] = '{32'h0000_0400, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0480, 1'b1, 8'h00, 4'h1, 1'b1, 32'h0000_0480, 32'd2, 32'd1};
    vecs[2] = '{32'h0000_0200, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0340, 1'b1, 8'h80, 4'h0, 1'b1, 32'h0000_0340, 32'd3, 32'd2};
    vecs[3] = '{32'h0000_0200, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0300, 1'b1, 8'h80, 4'h0, 1'b1, 32'h0000_0204, 32'd4, 32'd3};
    vecs[4] = '{32'h0000_0200, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 8'h80, 4'h0, 1'b0, 32'h0000_0204, 32'd5, 32'd3};
    vecs[5] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 8'hFF, 4'hF, 1'b1, 32'h0000_0000, 32'd6, 32'd4};
    vecs[6] = '{32'h0000_3C08, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 8'h02, 4'hF, 1'b0, 32'h0000_0000, 32'd7, 32'd4};
    vecs[7] = '{32'h0000_0500, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0900, 1'b0, 8'h00, 4'h0, 1'b0, 32'h0000_0000, 32'd7, 32'd4};

    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    chk("rst_we",    {31'd0, btb_we_o},   32'd0);
    chk("rst_redir", {31'd0, redirect_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o},    32'd0);
    chk("rst_rpc",   redirect_pc_o,       32'd0);
    chk("rst_bcnt",  branch_cnt_o,        32'd0);
    chk("rst_mcnt",  mispred_cnt_o,       32'd0);
    rst_i = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // Mispredict kills the younger instructions in ID and IF->ID.
    if_valid_i = 1'b1; if_pc_i = 32'h0000_0600; if_pred_taken_i = 1'b0;
    tick();
    if_pc_i = 32'h0000_0700;
    tick();
    if_pc_i = 32'h0000_0800;
    ex_is_branch_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h0000_0900;
    tick();
    chk("kill_redir", {31'd0, redirect_o}, 32'd1);
    chk("kill_flush", {31'd0, flush_o},    32'd1);
    chk("kill_rpc",   redirect_pc_o,       32'h0000_0900);
    chk("kill_mcnt",  mispred_cnt_o,       32'd5);
    if_valid_i = 1'b0; ex_taken_i = 1'b0;
    tick();
    chk("kill_we1",    {31'd0, btb_we_o},   32'd0);
    chk("kill_redir1", {31'd0, redirect_o}, 32'd0);
    tick();
    chk("kill_we2", {31'd0, btb_we_o}, 32'd0);
    tick();
    chk("kill_bcnt", branch_cnt_o,  32'd8);
    chk("kill_mcnt2", mispred_cnt_o, 32'd5);
    ex_is_branch_i = 1'b0;

    // Stalled branch resolves exactly once.
    load_ex(32'h0000_0A00, 1'b0, 32'd0);
    stall_i = 1'b1; ex_is_branch_i = 1'b1; ex_taken_i = 1'b0; ex_target_i = 32'h0000_0A80;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (btb_we_o) pulses++;
    end
    stall_i = 1'b0;
    tick();
    if (btb_we_o) pulses++;
    ex_is_branch_i = 1'b0;
    tick();
    if (btb_we_o) pulses++;
    chk("stall_pulses", pulses,        32'd1);
    chk("stall_bcnt",   branch_cnt_o,  32'd9);
    chk("stall_mcnt",   mispred_cnt_o, 32'd5);

    // Saturation at all-ones.
    @(negedge clk_i);
    force dut.branch_cnt_q  = 32'hFFFF_FFFF;
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    release dut.mispred_cnt_q;
    load_ex(32'h0000_0200, 1'b0, 32'd0);
    ex_is_branch_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h0000_0240;
    tick();
    chk("sat_redir", {31'd0, redirect_o}, 32'd1);
    chk("sat_bcnt",  branch_cnt_o,        32'hFFFF_FFFF);
    chk("sat_mcnt",  mispred_cnt_o,       32'hFFFF_FFFF);
    ex_is_branch_i = 1'b0;
    tick();

    // Async reset in the FLUSH cycle.
    load_ex(32'h0000_0400, 1'b0, 32'd0);
    ex_is_branch_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h0000_0480;
    tick();
    chk("arst_pre_redir", {31'd0, redirect_o}, 32'd1);
    ex_is_branch_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_redir", {31'd0, redirect_o}, 32'd0);
    chk("arst_flush", {31'd0, flush_o},    32'd0);
    chk("arst_we",    {31'd0, btb_we_o},   32'd0);
    chk("arst_rpc",   redirect_pc_o,       32'd0);
    chk("arst_bcnt",  branch_cnt_o,        32'd0);
    chk("arst_mcnt",  mispred_cnt_o,       32'd0);
    chk("arst_fsm",   {31'd0, dut.state_q}, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // After reset the unit is back in IDLE and redirects again.
    load_ex(32'h0000_0400, 1'b0, 32'd0);
    ex_is_branch_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h0000_0480;
    tick();
    chk("post_rst_redir", {31'd0, redirect_o}, 32'd1);
    chk("post_rst_bcnt",  branch_cnt_o,        32'd1);
    ex_is_branch_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
